// File: rtl/rv32i_mem_arbiter_if.sv
// rv32i_mem_arbiter_if: fetch, data and memory signals of the arbiter; slave = arbiter view, master = environment view
interface rv32i_mem_arbiter_if;
  logic        i_inst_req;
  logic [31:0] i_inst_addr;
  logic [31:0] o_inst;
  logic        o_inst_ack;
  logic        i_data_req;
  logic        i_data_wr;
  logic [31:0] i_data_addr;
  logic [31:0] i_data_wdata;
  logic [3:0]  i_data_wmask;
  logic [31:0] o_data_rdata;
  logic        o_data_ack;
  logic        o_err;
  logic        o_mem_req;
  logic        o_mem_wr;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_wmask;
  logic [31:0] i_mem_rdata;
  logic        i_mem_ack;
  modport slave (
    input  i_inst_req, i_inst_addr, i_data_req, i_data_wr, i_data_addr, i_data_wdata, i_data_wmask, i_mem_rdata, i_mem_ack,
    output o_inst, o_inst_ack, o_data_rdata, o_data_ack, o_err, o_mem_req, o_mem_wr, o_mem_addr, o_mem_wdata, o_mem_wmask
  );
  modport master (
    output i_inst_req, i_inst_addr, i_data_req, i_data_wr, i_data_addr, i_data_wdata, i_data_wmask, i_mem_rdata, i_mem_ack,
    input  o_inst, o_inst_ack, o_data_rdata, o_data_ack, o_err, o_mem_req, o_mem_wr, o_mem_addr, o_mem_wdata, o_mem_wmask
  );
endinterface

// File: rtl/rv32i_mem_arbiter.sv
// rv32i_mem_arbiter: fetch/data to single memory port arbiter (data-first, fetch anti-starvation, ack timeout); ports i_clk, i_rst_n (async low), bus (rv32i_mem_arbiter_if.slave)
module rv32i_mem_arbiter #(
  parameter int unsigned MAX_DATA_STREAK = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input logic                i_clk,
  input logic                i_rst_n,
  rv32i_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY_INST, BUSY_DATA, DONE} state_t;
  state_t      state, state_nxt;
  logic [3:0]  streak;
  logic [9:0]  tmo_cnt;
  logic        sel_inst, err_q, wr_q;
  logic [3:0]  wmask_q;
  logic [31:0] addr_q, wdata_q, inst_q, rdata_q;
  logic        idle, busy, inst_win, data_win, tmo_hit, fin;
  assign idle     = state == IDLE;
  assign busy     = state == BUSY_INST || state == BUSY_DATA;
  assign inst_win = idle && bus.i_inst_req && (!bus.i_data_req || streak == 4'(MAX_DATA_STREAK));
  assign data_win = idle && bus.i_data_req && !inst_win;
  // tmo_cnt counts finished BUSY cycles, so the current cycle is the last one allowed
  assign tmo_hit  = ({1'b0, tmo_cnt} + 11'd1) == 11'(TIMEOUT_CYCLES);
  assign fin      = busy && (bus.i_mem_ack || tmo_hit);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = inst_win ? BUSY_INST : data_win ? BUSY_DATA : fin ? DONE : busy ? state : IDLE;
  always_comb begin
    bus.o_mem_req    = busy;
    bus.o_inst_ack   = state == DONE && sel_inst;
    bus.o_data_ack   = state == DONE && !sel_inst;
    bus.o_err        = state == DONE && err_q;
    bus.o_mem_wr     = wr_q;
    bus.o_mem_addr   = addr_q;
    bus.o_mem_wdata  = wdata_q;
    bus.o_mem_wmask  = wmask_q;
    bus.o_inst       = inst_q;
    bus.o_data_rdata = rdata_q;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      streak   <= '0;
      tmo_cnt  <= '0;
      sel_inst <= 1'b0;
      err_q    <= 1'b0;
      wr_q     <= 1'b0;
      wmask_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      inst_q   <= '0;
      rdata_q  <= '0;
    end else begin
      // a data grant reaching this branch always has fetch waiting; the grant rule caps the streak
      if (inst_win || (idle && !bus.i_inst_req)) streak <= '0;
      else if (data_win) streak <= streak + 4'd1;
      if (inst_win || data_win) begin
        sel_inst <= inst_win;
        err_q    <= 1'b0;
        tmo_cnt  <= '0;
        addr_q   <= inst_win ? bus.i_inst_addr : bus.i_data_addr;
        wr_q     <= data_win && bus.i_data_wr;
        wdata_q  <= inst_win ? '0 : bus.i_data_wdata;
        wmask_q  <= (data_win && bus.i_data_wr) ? bus.i_data_wmask : '0;
      end
      if (busy) tmo_cnt <= tmo_cnt + 10'd1;
      if (fin) begin
        err_q <= !bus.i_mem_ack;
        if (sel_inst) inst_q <= bus.i_mem_ack ? bus.i_mem_rdata : '0;
        else rdata_q <= bus.i_mem_ack ? bus.i_mem_rdata : '0;
      end
    end
endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// tb_rv32i_mem_arbiter: randomized and directed bench with a transaction-level reference model
module tb_rv32i_mem_arbiter;
  localparam int MAX = 4;
  localparam int TMO = 8;
  logic clk, rst_n;
  rv32i_mem_arbiter_if bus();
  rv32i_mem_arbiter #(.MAX_DATA_STREAK(MAX), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .bus(bus)
  );
  int n_tests = 0, n_fail = 0, cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // reference model: owner 0 none / 1 fetch / 2 data, fin = completion cycle, age = BUSY cycles spent
  int owner, age, m_streak;
  bit fin, m_err, take_i, m_busy;
  logic [31:0] m_inst, m_rdata, m_addr, m_wdata;
  logic m_wr;
  logic [3:0] m_wmask;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner = 0; fin = 0; m_err = 0; age = 0; m_streak = 0;
      m_inst = '0; m_rdata = '0; m_addr = '0; m_wdata = '0; m_wr = 0; m_wmask = '0;
    end else if (fin) begin
      fin = 0; owner = 0;
    end else if (owner != 0) begin
      age++;
      if (bus.i_mem_ack || age == TMO) begin
        fin = 1;
        m_err = !bus.i_mem_ack;
        if (owner == 1) m_inst = bus.i_mem_ack ? bus.i_mem_rdata : '0;
        else m_rdata = bus.i_mem_ack ? bus.i_mem_rdata : '0;
      end
    end else begin
      take_i = bus.i_inst_req && (!bus.i_data_req || m_streak == MAX);
      if (take_i) begin
        owner = 1; m_addr = bus.i_inst_addr; m_wr = 0; m_wdata = '0; m_wmask = '0;
      end else if (bus.i_data_req) begin
        owner = 2; m_addr = bus.i_data_addr; m_wr = bus.i_data_wr; m_wdata = bus.i_data_wdata;
        m_wmask = bus.i_data_wr ? bus.i_data_wmask : 4'h0;
      end
      age = 0;
      m_streak = (take_i || !bus.i_inst_req) ? 0 : bus.i_data_req ? ((m_streak < MAX) ? m_streak + 1 : MAX) : m_streak;
    end
  end
  bit log_en = 0, prev_obs = 0;
  int log_max = 0;
  byte glog[$];
  int gcyc[$];
  always @(negedge clk) begin
    m_busy = owner != 0 && !fin;
    check("mem_req", 32'(bus.o_mem_req), 32'(m_busy));
    check("inst_ack", 32'(bus.o_inst_ack), 32'(fin && owner == 1));
    check("data_ack", 32'(bus.o_data_ack), 32'(fin && owner == 2));
    check("err", 32'(bus.o_err), 32'(fin && m_err));
    check("inst", bus.o_inst, m_inst);
    check("rdata", bus.o_data_rdata, m_rdata);
    if (m_busy) begin
      check("mem_addr", bus.o_mem_addr, m_addr);
      check("mem_wr", 32'(bus.o_mem_wr), 32'(m_wr));
      check("mem_wmask", 32'(bus.o_mem_wmask), 32'(m_wmask));
      if (owner == 1 || m_wr) check("mem_wdata", bus.o_mem_wdata, m_wdata);
    end
    if (log_en && bus.o_mem_req && !prev_obs && glog.size() < log_max) begin
      glog.push_back(bus.o_mem_addr[17] ? 8'd68 : 8'd73);
      gcyc.push_back(cyc);
    end
    prev_obs = bus.o_mem_req;
  end
  // memory: mem_delay >= 0 fixed wait, -1 never acks, -2 random wait 0..9
  int mem_delay = 0, wl = 0;
  bit mem_rand = 0, stray = 0, prev_mreq = 0;
  logic [31:0] next_rdata = '0;
  initial begin
    bus.i_mem_ack = 1'b0;
    bus.i_mem_rdata = '0;
    forever begin
      @(posedge clk); #2;
      bus.i_mem_rdata = mem_rand ? $urandom : next_rdata;
      bus.i_mem_ack = stray;
      if (bus.o_mem_req) begin
        if (!prev_mreq) wl = (mem_delay == -1) ? 32'h7fff_ffff : (mem_delay == -2) ? int'($urandom_range(0, 9)) : mem_delay;
        if (wl == 0) bus.i_mem_ack = 1'b1;
        else wl--;
      end
      prev_mreq = bus.o_mem_req;
    end
  end
  logic [31:0] s_addr, s_wdata;
  logic s_wr;
  logic [3:0] s_mask;
  task automatic run_txn(input bit inst, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] mask, output int rc, output bit got);
    @(posedge clk); #2;
    if (inst) begin
      bus.i_inst_req = 1'b1; bus.i_inst_addr = addr;
    end else begin
      bus.i_data_req = 1'b1; bus.i_data_wr = wr; bus.i_data_addr = addr;
      bus.i_data_wdata = wdata; bus.i_data_wmask = mask;
    end
    rc = 0; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus.o_mem_req) begin
        rc++;
        s_addr = bus.o_mem_addr; s_wr = bus.o_mem_wr; s_wdata = bus.o_mem_wdata; s_mask = bus.o_mem_wmask;
      end
      got = inst ? bus.o_inst_ack : bus.o_data_ack;
    end
    check(inst ? "inst_ack_seen" : "data_ack_seen", 32'(got), 32'd1);
    bus.i_inst_req = 1'b0;
    bus.i_data_req = 1'b0;
  endtask
  // mode 1: request continuously, mode 2: random on/off; each port re-requests on its ack
  task automatic auto_run(input int im, input int dm, input int max_cyc, input int want);
    for (int c = 0; c < max_cyc && glog.size() < want; c++) begin
      @(posedge clk); #2;
      if (im != 0 && (bus.o_inst_ack || !bus.i_inst_req)) begin
        bus.i_inst_req = im == 1 || $urandom_range(0, 2) != 0;
        bus.i_inst_addr = 32'h0001_0000 | ($urandom & 32'h0000_fffc);
      end
      if (dm != 0 && (bus.o_data_ack || !bus.i_data_req)) begin
        bus.i_data_req = dm == 1 || $urandom_range(0, 2) != 0;
        bus.i_data_wr = 1'($urandom_range(0, 1));
        bus.i_data_addr = 32'h0002_0000 | ($urandom & 32'h0000_fffc);
        bus.i_data_wdata = $urandom;
        bus.i_data_wmask = 4'($urandom_range(0, 15));
      end
    end
    for (int c = 0; c < 300 && (bus.i_inst_req || bus.i_data_req); c++) begin
      @(posedge clk); #2;
      if (bus.o_inst_ack) bus.i_inst_req = 1'b0;
      if (bus.o_data_ack) bus.i_data_req = 1'b0;
    end
    check("drain", 32'(bus.i_inst_req || bus.i_data_req), 32'd0);
    repeat (3) @(posedge clk);
  endtask
  task automatic check_zero(input string p);
    check({p, "_inst"}, bus.o_inst, 32'd0);
    check({p, "_inst_ack"}, 32'(bus.o_inst_ack), 32'd0);
    check({p, "_rdata"}, bus.o_data_rdata, 32'd0);
    check({p, "_data_ack"}, 32'(bus.o_data_ack), 32'd0);
    check({p, "_err"}, 32'(bus.o_err), 32'd0);
    check({p, "_mem_req"}, 32'(bus.o_mem_req), 32'd0);
    check({p, "_mem_wr"}, 32'(bus.o_mem_wr), 32'd0);
    check({p, "_mem_addr"}, bus.o_mem_addr, 32'd0);
    check({p, "_mem_wdata"}, bus.o_mem_wdata, 32'd0);
    check({p, "_mem_wmask"}, 32'(bus.o_mem_wmask), 32'd0);
  endtask
  int rc;
  bit got;
  string exp_s;
  initial begin
    rst_n = 1'b1;
    bus.i_inst_req = 1'b0; bus.i_inst_addr = '0;
    bus.i_data_req = 1'b0; bus.i_data_wr = 1'b0; bus.i_data_addr = '0;
    bus.i_data_wdata = '0; bus.i_data_wmask = '0;
    #1 rst_n = 1'b0;
    #1 check_zero("reset");
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    mem_delay = 0; next_rdata = 32'hCAFE_F00D;
    run_txn(1, 0, 32'h0000_2ffc, '0, '0, rc, got);
    check("fetch_inst", bus.o_inst, 32'hCAFE_F00D);
    check("fetch_wr", 32'(s_wr), 32'd0);
    check("fetch_wmask", 32'(s_mask), 32'd0);
    check("fetch_wdata", s_wdata, 32'd0);
    mem_delay = -1;
    run_txn(1, 0, 32'h0000_3000, '0, '0, rc, got);
    check("tmo_req_cycles", 32'(rc), 32'd8);
    check("tmo_err", 32'(bus.o_err), 32'd1);
    check("tmo_inst", bus.o_inst, 32'd0);
    @(negedge clk);
    check("tmo_err_after", 32'(bus.o_err), 32'd0);
    mem_delay = 1; next_rdata = 32'h1234_5678;
    run_txn(1, 0, 32'h0000_3004, '0, '0, rc, got);
    check("post_tmo_req_cycles", 32'(rc), 32'd2);
    check("post_tmo_err", 32'(bus.o_err), 32'd0);
    check("post_tmo_inst", bus.o_inst, 32'h1234_5678);
    mem_delay = 2; next_rdata = 32'hDEAD_BEEF;
    run_txn(0, 0, 32'h0000_0100, 32'h5555_5555, 4'hf, rc, got);
    check("load_req_cycles", 32'(rc), 32'd3);
    check("load_addr", s_addr, 32'h0000_0100);
    check("load_wr", 32'(s_wr), 32'd0);
    check("load_wmask", 32'(s_mask), 32'd0);
    check("load_rdata", bus.o_data_rdata, 32'hDEAD_BEEF);
    check("load_inst_kept", bus.o_inst, 32'h1234_5678);
    @(negedge clk);
    check("load_ack_pulse", 32'(bus.o_data_ack), 32'd0);
    mem_delay = 0; next_rdata = 32'h0BAD_0BAD;
    run_txn(0, 1, 32'h0000_0204, 32'h0000_AB00, 4'b0010, rc, got);
    check("store_req_cycles", 32'(rc), 32'd1);
    check("store_addr", s_addr, 32'h0000_0204);
    check("store_wr", 32'(s_wr), 32'd1);
    check("store_wdata", s_wdata, 32'h0000_AB00);
    check("store_wmask", 32'(s_mask), 32'b0010);
    check("store_err", 32'(bus.o_err), 32'd0);
    glog.delete(); gcyc.delete(); log_max = 10; log_en = 1;
    auto_run(1, 1, 200, 10);
    log_en = 0;
    exp_s = "DDDDIDDDDI";
    check("contend_grants", 32'(glog.size()), 32'd10);
    for (int i = 0; i < glog.size(); i++) check("contend_order", 32'(glog[i]), 32'(exp_s[i]));
    glog.delete(); gcyc.delete(); log_max = 6; log_en = 1;
    auto_run(1, 0, 60, 6);
    log_en = 0;
    check("fetch_only_grants", 32'(glog.size()), 32'd6);
    for (int i = 1; i < gcyc.size(); i++) check("fetch_only_gap", 32'(gcyc[i] - gcyc[i-1]), 32'd3);
    for (int i = 0; i < glog.size(); i++) check("fetch_only_port", 32'(glog[i]), 32'd73);
    check("fetch_only_streak", 32'(m_streak), 32'd0);
    mem_delay = -2; mem_rand = 1;
    auto_run(2, 2, 1500, 32'h7fff_ffff);
    mem_delay = -1; mem_rand = 0;
    @(posedge clk); #2;
    bus.i_data_req = 1'b1; bus.i_data_wr = 1'b0; bus.i_data_addr = 32'h0000_0400;
    repeat (3) @(negedge clk);
    check("rst_busy_req", 32'(bus.o_mem_req), 32'd1);
    #1 rst_n = 1'b0;
    #1 check_zero("async_rst");
    bus.i_data_req = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    stray = 1;
    repeat (4) begin
      @(negedge clk);
      check("stray_data_ack", 32'(bus.o_data_ack), 32'd0);
      check("stray_inst_ack", 32'(bus.o_inst_ack), 32'd0);
      check("stray_mem_req", 32'(bus.o_mem_req), 32'd0);
    end
    stray = 0;
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish, %0d tests run", n_tests);
    $fatal(1);
  end
endmodule
